// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared state encoding and widths for the ADC capture sequencer
package adc_capture_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POWERUP   = 3'd1,
        START     = 3'd2,
        WAIT_DRDY = 3'd3,
        SHIFT     = 3'd4,
        PUSH      = 3'd5
    } state_e;

    localparam int DEFAULT_DATA_BITS = 24;
    localparam int DROP_CNT_W        = 16;

endpackage

// File: rtl/adc_if_sync.sv
// rtl/adc_if_sync.sv - 2-flop synchronizers and edge detection for the ADC serial pins
module adc_if_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sclk_i,
    input  logic drdy_i,
    input  logic dout_i,
    output logic sclk_rise_o,
    output logic drdy_fall_o,
    output logic dout_s_o
);

    // [0],[1] form the synchronizer; [2] is the previous synchronized value for edge detect
    logic [2:0] sclk_q;
    logic [2:0] drdy_q;
    logic [1:0] dout_q;

    // drdy resets to its idle (high) level; sclk/dout reset low
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q <= 3'b000;
            drdy_q <= 3'b111;
            dout_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk_i};
            drdy_q <= {drdy_q[1:0], drdy_i};
            dout_q <= {dout_q[0], dout_i};
        end
    end

    // dout travels the same depth as sclk so data is aligned with its rising edge
    assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
    assign drdy_fall_o = ~drdy_q[1] & drdy_q[2];
    assign dout_s_o    = dout_q[1];

endmodule

// File: rtl/adc_capture_sequencer.sv
// rtl/adc_capture_sequencer.sv - ADC power-up/start sequencing and DRDY-framed sample capture to a stream (option: ADC_CAPTURE_TEST_PATTERN_EN)
module adc_capture_sequencer
    import adc_capture_pkg::*;
#(
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int OUT_BITS     = 32,
    parameter int PWRUP_CYCLES = 1000,
    parameter int START_CYCLES = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic                  sclk,
    input  logic                  drdy,
    input  logic                  dout,
    output logic                  pown,
    output logic                  start,
    output logic [OUT_BITS-1:0]   m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int CNT_MAX = (PWRUP_CYCLES > START_CYCLES) ? PWRUP_CYCLES : START_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_BITS + 1);

    logic sclk_rise;
    logic drdy_fall;
    logic dout_s;

    adc_if_sync u_sync (
        .clk_i       (aclk),
        .rst_ni      (aresetn),
        .sclk_i      (sclk),
        .drdy_i      (drdy),
        .dout_i      (dout),
        .sclk_rise_o (sclk_rise),
        .drdy_fall_o (drdy_fall),
        .dout_s_o    (dout_s)
    );

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]    sr_q, sr_d;
    logic [OUT_BITS-1:0]     tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    pown_q, pown_d;
    logic                    start_q, start_d;
    logic                    busy_q;
    logic                    overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;
    logic                    enable_q;
    logic                    drop_hit;
    logic                    word_done;
    logic [DATA_BITS-1:0]    shifted;
    logic [DATA_BITS-1:0]    new_word;

    assign shifted = {sr_q[DATA_BITS-2:0], dout_s};

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    logic [DATA_BITS-1:0] pat_q;

    // Pattern word advances once per completed frame; dout never reaches the stream
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pat_q <= '0;
        end else if (word_done) begin
            pat_q <= pat_q + DATA_BITS'(1);
        end
    end

    assign new_word = pat_q;
`else
    assign new_word = shifted;
`endif

    // Next-state, datapath and sticky drop accounting
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        drop_hit   = 1'b0;
        word_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = POWERUP;
                    cnt_d   = '0;
                end
            end
            POWERUP: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) begin
                    state_d = START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            START: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
                    state_d = WAIT_DRDY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DRDY: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (drdy_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (drdy_fall) begin
                    // short frame: restart on the new frame without counting a drop
                    bit_cnt_d = '0;
                end else if (sclk_rise) begin
                    sr_d = shifted;
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d   = PUSH;
                        tvalid_d  = 1'b1;
                        tdata_d   = OUT_BITS'(signed'(new_word));
                        word_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PUSH: begin
                // a frame starting while the beat is still pending is lost
                drop_hit = drdy_fall;
                if (m_axis_tready) begin
                    tvalid_d = 1'b0;
                    state_d  = enable ? WAIT_DRDY : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        overflow_d = (enable && !enable_q) ? 1'b0 : overflow_q;
        drop_d     = (enable && !enable_q) ? '0 : drop_q;
        if (drop_hit) begin
            overflow_d = 1'b1;
            if (drop_d != {DROP_CNT_W{1'b1}}) begin
                drop_d = drop_d + DROP_CNT_W'(1);
            end
        end

        pown_d  = (state_d != IDLE);
        start_d = (state_d == START);
    end

    // All sequencer state and registered outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            pown_q     <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            enable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            pown_q     <= pown_d;
            start_q    <= start_d;
            busy_q     <= (state_q != IDLE);
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            enable_q   <= enable;
        end
    end

    assign pown          = pown_q;
    assign start         = start_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = busy_q;
    assign overflow      = overflow_q;
    assign drop_count    = drop_q;

endmodule

// File: doc/adc_capture_sequencer.md
# adc_capture_sequencer

Sequences one ADS1675-class ADC channel from power-up to streamed samples. Sits between the ADC enable GPIO bit and the axi4l_fifo write side. Powers up and starts the converter, then deserializes each DRDY-framed serial word. Sign-extends the word and presents it as an AXI-Stream beat, accounting for samples dropped under FIFO back-pressure.

## Interface
- DATA_BITS, 24, serial word width from ADC (MSB first)
- OUT_BITS, 32, stream width; must be ≥ DATA_BITS
- PWRUP_CYCLES, 1000, aclk cycles pown held high before start
- START_CYCLES, 4, width of start pulse in aclk cycles
- aclk  in  1  system clock; one clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  capture enable (GPIO), level-sensitive
- sclk, drdy, dout  in  1  ADC serial clock / data-ready (active-low frame) / data, asynchronous to aclk
- pown  out  1  ADC power-down, active-low (1 = powered)
- start  out  1  ADC start pulse
- m_axis_tdata  out  OUT_BITS  sign-extended sample
- m_axis_tvalid  out  1  sample valid
- m_axis_tready  in  1  sink ready
- busy  out  1  state ≠ IDLE
- overflow  out  1  sticky; set when a sample is dropped, cleared only by reset or enable rising edge
- drop_count  out  16  samples dropped; saturates at 16'hFFFF; cleared with overflow

## Operation
- Reset values: pown=0, start=0, m_axis_tdata=0, m_axis_tvalid=0, busy=0, overflow=0, drop_count=0, state=IDLE.
- sclk/drdy/dout pass through 2-flop synchronizers. Edge detect yields sclk_rise and drdy_fall.
- The design requires an aclk frequency ≥ 3× the sclk frequency.
- IDLE: enable=1 → POWERUP. An enable rising edge clears overflow and drop_count.
- POWERUP: pown=1; counter runs PWRUP_CYCLES; on expiry → START.
- START: start=1 for START_CYCLES; → WAIT_DRDY.
- WAIT_DRDY: drdy_fall → SHIFT, bit counter=0.
- SHIFT: on each sclk_rise, shift synced dout into the LSB of the shift register. After DATA_BITS bits → PUSH.
- PUSH: tdata={{(OUT_BITS-DATA_BITS){sr[MSB]}},sr}, tvalid=1. Hold tdata/tvalid stable until tvalid&&tready. On handshake → WAIT_DRDY.
- Overflow: if drdy_fall is detected in PUSH, the in-flight beat is kept. The new frame is dropped: drop_count++, overflow=1. The FSM skips that frame and waits for the next drdy_fall after the handshake.
- Disable (enable=0):
  - POWERUP/START/WAIT_DRDY → IDLE next cycle.
  - SHIFT → partial word discarded, IDLE.
  - PUSH → stays until the handshake, then IDLE; tvalid is never retracted.
  - pown and start drop to 0 on entering IDLE.
- drdy_fall during SHIFT (short frame): restart the shift with counter=0, no drop counted.
- Asynchronous reset mid-frame: all state to reset values immediately; no partial beat emitted.

## Timing
- drdy/sclk pin-to-edge-detect latency: 3 aclk cycles.
- tvalid rises on the cycle after the DATA_BITS-th sclk_rise is detected.
- start asserts on cycle PWRUP_CYCLES+1 after the first cycle enable is seen high in IDLE. It is high for exactly START_CYCLES cycles.
- A beat with tready held at 1 completes in the cycle tvalid rises. Sustained throughput: one sample per DRDY frame.
- busy is registered and follows the state with 1-cycle latency.

## Configuration
- ADC_CAPTURE_TEST_PATTERN_EN defined: the shift-register input is replaced by an internal DATA_BITS counter. The counter starts at 0 and increments once per completed frame. Frame timing still comes from sclk/drdy; dout is ignored. Used for FIFO/driver bring-up.
- Undefined: samples come from dout only; the counter logic is absent.

## Structure
- Package adc_capture_pkg: state enum (IDLE, POWERUP, START, WAIT_DRDY, SHIFT, PUSH), DEFAULT_DATA_BITS=24, DROP_CNT_W=16.
- Sub-module adc_if_sync: 2-flop synchronizers plus edge detection for sclk, drdy and dout. Outputs sclk_rise, drdy_fall and dout_s.

## Test plan
- PWRUP_CYCLES=10, START_CYCLES=4, enable↑ → pown=1 on the next cycle; start high for cycles 11–14; busy=1.
- Model frame 24'h800001, tready=1 → single beat tdata=32'hFF800001; frame 24'h7FFFFF → 32'h007FFFFF.
- tready=0 across two DRDY frames → first beat held stable; second frame dropped; overflow=1, drop_count=1. tready=1 then delivers only the first sample.
- enable↓ mid-SHIFT (after 10 bits) → IDLE, no beat, pown=0. enable↓ during PUSH with tready=0 → tvalid held until tready=1, then IDLE.
- aresetn asserted mid-frame → all outputs 0 asynchronously. After release and enable↑, the next full frame streams correctly.
- With ADC_CAPTURE_TEST_PATTERN_EN, 300 frames → tdata 0,1,…,299 in order, drop_count=0.
